servo_slew_limiter: RTL and testbench
=====================================

SERVO_SLEW_LIMITER -- requirements
Module: servo_slew_limiter

Interface
REQ-001 Parameter FRAME_CYCLES, default 2000000, SHALL set the servo frame length in clock cycles (20 ms at 100 MHz); legal when >= 2.
REQ-002 Parameter MIN_PW, default 100000, SHALL be the lowest commandable pulse width in clock cycles (1 ms).
REQ-003 Parameter MAX_PW, default 200000, SHALL be the highest commandable pulse width in clock cycles (2 ms).
REQ-004 Parameter CENTER_PW, default 150000, SHALL be the reset pulse width; legal when MIN_PW <= CENTER_PW <= MAX_PW.
REQ-005 Parameter STEP, default 2000, SHALL be the maximum pulse-width change per frame; legal when >= 1.
REQ-006 clock  input  1  SHALL be the single system clock; all state updates on its rising edge.
REQ-007 reset  input  1  SHALL be the asynchronous, active-low reset (0 = reset asserted).
REQ-008 target  input  32  SHALL be the requested pulse width in clock cycles, written by the register file; unsigned.
REQ-009 enable  input  1  SHALL permit ramping when 1 and freeze pulse_width when 0.
REQ-010 pulse_width  output  32  SHALL be the slew-limited pulse width fed to the downstream dff32/PWM stage.
REQ-011 frame_tick  output  1  SHALL be a one-cycle frame-boundary strobe.
REQ-012 busy  output  1  SHALL be 1 while the state is UP or DOWN.
REQ-013 at_target  output  1  SHALL be 1 while the state is IDLE.

Function
REQ-014 Frame counter SHALL count 0..FRAME_CYCLES-1, wrap to 0, and run regardless of enable.
REQ-015 frame_tick SHALL be decoded from the counter register: high exactly in the cycle where the counter equals FRAME_CYCLES-1.
REQ-016 Clamped target tgt_c SHALL be registered every cycle as tgt_c = target clamped to [MIN_PW, MAX_PW], using unsigned comparison; this adds 1 cycle of latency.
REQ-017 On the rising edge ending a frame_tick cycle with enable=1: if pulse_width < tgt_c, then pulse_width <= min(pulse_width+STEP, tgt_c); if pulse_width > tgt_c, then pulse_width <= max(pulse_width-STEP, tgt_c); otherwise hold.
REQ-018 pulse_width SHALL change at no edge other than those in REQ-017; with enable=0 it SHALL hold indefinitely.
REQ-019 pulse_width SHALL never overshoot tgt_c and SHALL always lie in [MIN_PW, MAX_PW].
REQ-020 Intermediate arithmetic SHALL be at least 33 bits wide, or otherwise overflow-safe, so that pulse_width+STEP cannot wrap.
REQ-021 State machine states are IDLE (pulse_width == tgt_c), UP (pulse_width < tgt_c) and DOWN (pulse_width > tgt_c); the state SHALL be registered and recomputed every cycle from the next-cycle values of pulse_width and tgt_c.
REQ-022 A target change mid-ramp SHALL take effect at the next tick; a direction reversal SHALL occur without an extra frame of delay.
REQ-023 When enable rises, ramping SHALL resume at the next frame_tick; the frame phase SHALL NOT be reset.

Reset
REQ-024 While reset=0, all outputs SHALL immediately take these values: pulse_width=CENTER_PW, tgt_c=CENTER_PW, counter=0, frame_tick=0, state IDLE (busy=0, at_target=1).
REQ-025 After reset deasserts, the first frame_tick SHALL occur FRAME_CYCLES-1 rising edges later.
REQ-026 Reset asserted mid-ramp or mid-frame SHALL abort the ramp and restore all REQ-024 values asynchronously.

Verification (bench parameters FRAME_CYCLES=10, MIN_PW=100, MAX_PW=200, CENTER_PW=150, STEP=20)
REQ-027 Pull reset low at counter=4 during a ramp -> pulse_width=150, frame_tick=0, busy=0, at_target=1 without waiting for a clock edge; first tick follows 9 edges after release.
REQ-028 Hold target=200, enable=1 -> pulse_width 150, 170, 190, 200 at successive ticks; busy=1 until the 200 update, then at_target=1.
REQ-029 Set target=0 -> tgt_c=100; pulse_width 150, 130, 110, 100; pulse_width never below 100.
REQ-030 Set target=200; after the tick that yields 170, set target=160 -> next tick gives 160 (no overshoot), then IDLE.
REQ-031 Set target=200 with enable=0 for 3 frames -> pulse_width stays 150 while frame_tick still pulses every 10 cycles; set enable=1 -> 170 at the next tick.
REQ-032 Set target=32'hFFFFFFFF -> tgt_c=200; the ramp ends at exactly 200 with no arithmetic wrap.

Source files
------------

// File: rtl/servo_slew_limiter.sv
// Servo pulse-width slew limiter: moves pulse_width toward a clamped target by at most STEP once per frame.
// Latency: target reaches tgt_c after 1 cycle and pulse_width at the edge ending the next frame tick; no backpressure, runs every cycle.
module servo_slew_limiter #(
  parameter int unsigned FRAME_CYCLES = 2000000,
  parameter int unsigned MIN_PW       = 100000,
  parameter int unsigned MAX_PW       = 200000,
  parameter int unsigned CENTER_PW    = 150000,
  parameter int unsigned STEP         = 2000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] target,
  input  logic        enable,
  output logic [31:0] pulse_width,
  output logic        frame_tick,
  output logic        busy,
  output logic        at_target
);

  localparam int unsigned   CW       = $clog2(FRAME_CYCLES);
  localparam logic [CW-1:0] LAST     = CW'(FRAME_CYCLES - 1);
  localparam logic [31:0]   MIN_V    = 32'(MIN_PW);
  localparam logic [31:0]   MAX_V    = 32'(MAX_PW);
  localparam logic [31:0]   CENTER_V = 32'(CENTER_PW);
  localparam logic [31:0]   STEP_V   = 32'(STEP);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } state_t;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   tgt_c_q, tgt_c_d;
  logic [31:0]   pw_q, pw_d;
  logic [31:0]   gap;
  state_t        state_q, state_d;

  assign frame_tick  = (cnt_q == LAST);
  assign pulse_width = pw_q;
  assign busy        = (state_q != IDLE);
  assign at_target   = (state_q == IDLE);

  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
  end

  always_comb begin
    tgt_c_d = target;
    if (target < MIN_V) begin
      tgt_c_d = MIN_V;
    end else if (target > MAX_V) begin
      tgt_c_d = MAX_V;
    end
  end

  // Step only when the remaining gap exceeds STEP, so pw+STEP stays below
  // tgt_c (<= MAX_PW) and pw-STEP stays above it: no wrap in 32 bits.
  always_comb begin
    pw_d = pw_q;
    gap  = '0;
    if (frame_tick && enable) begin
      if (pw_q < tgt_c_q) begin
        gap  = tgt_c_q - pw_q;
        pw_d = (gap > STEP_V) ? pw_q + STEP_V : tgt_c_q;
      end else if (pw_q > tgt_c_q) begin
        gap  = pw_q - tgt_c_q;
        pw_d = (gap > STEP_V) ? pw_q - STEP_V : tgt_c_q;
      end
    end
  end

  // State tracks the values that will be registered this edge.
  always_comb begin
    state_d = IDLE;
    if (pw_d < tgt_c_d) begin
      state_d = UP;
    end else if (pw_d > tgt_c_d) begin
      state_d = DOWN;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      tgt_c_q <= CENTER_V;
      pw_q    <= CENTER_V;
      state_q <= IDLE;
    end else begin
      cnt_q   <= cnt_d;
      tgt_c_q <= tgt_c_d;
      pw_q    <= pw_d;
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_servo_slew_limiter.sv
// Bench for servo_slew_limiter: directed ramp scenarios plus randomized targets against a frame-level reference.
module tb_servo_slew_limiter;

  localparam int F      = 10;
  localparam int MIN_PW = 100;
  localparam int MAX_PW = 200;
  localparam int CTR_PW = 150;
  localparam int STEP   = 20;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] target = 32'd150;
  logic        enable = 1'b0;
  logic [31:0] pulse_width;
  logic        frame_tick;
  logic        busy;
  logic        at_target;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  servo_slew_limiter #(
    .FRAME_CYCLES(F),
    .MIN_PW(MIN_PW),
    .MAX_PW(MAX_PW),
    .CENTER_PW(CTR_PW),
    .STEP(STEP)
  ) dut (
    .clock(clock),
    .reset(reset),
    .target(target),
    .enable(enable),
    .pulse_width(pulse_width),
    .frame_tick(frame_tick),
    .busy(busy),
    .at_target(at_target)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: clamp the target, and once per frame move pw toward it by at most STEP.
  longint m_pw  = CTR_PW;
  longint m_tgt = CTR_PW;
  int     m_cnt = 0;

  function automatic longint clamp(input logic [31:0] t);
    longint v;
    v = longint'({32'd0, t});
    if (v < MIN_PW) return MIN_PW;
    if (v > MAX_PW) return MAX_PW;
    return v;
  endfunction

  function automatic longint ramp(input longint pw, input longint tg);
    if (pw < tg) return (pw + STEP < tg) ? pw + STEP : tg;
    if (pw > tg) return (pw - STEP > tg) ? pw - STEP : tg;
    return pw;
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_pw  <= CTR_PW;
      m_tgt <= CTR_PW;
      m_cnt <= 0;
    end else begin
      if (m_cnt == F - 1 && enable) m_pw <= ramp(m_pw, m_tgt);
      m_cnt <= (m_cnt + 1) % F;
      m_tgt <= clamp(target);
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      chk("pw",        pulse_width, 32'(m_pw));
      chk("tick",      32'(frame_tick), 32'(m_cnt == F - 1));
      chk("busy",      32'(busy), 32'(m_pw != m_tgt));
      chk("at_target", 32'(at_target), 32'(m_pw == m_tgt));
      chk("pw_range",  32'(pulse_width >= MIN_PW && pulse_width <= MAX_PW), 32'd1);
    end
  end

  // Called at a negedge: asserts reset mid-cycle, checks the async values, releases at the next negedge.
  task automatic do_reset();
    #2 reset = 1'b0;
    #1;
    chk("rst_pw",        pulse_width, 32'd150);
    chk("rst_tick",      32'(frame_tick), 32'd0);
    chk("rst_busy",      32'(busy), 32'd0);
    chk("rst_at_target", 32'(at_target), 32'd1);
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic cycles_to_tick(output int n);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!frame_tick && n < 40);
    if (n >= 40) chk("tick_timeout", 32'd0, 32'd1);
  endtask

  task automatic next_pw(output logic [31:0] pw);
    int n;
    cycles_to_tick(n);
    @(negedge clock);
    pw = pulse_width;
  endtask

  logic [31:0] pw;
  int          n;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  initial begin
    #1 reset = 1'b0;
    @(negedge clock);
    chk_en = 1'b1;
    do_reset();

    // Ramp up, then reset mid-ramp at counter=4 and restart the ramp.
    target = 32'd200; enable = 1'b1;
    cycles_to_tick(n);
    chk("first_tick_edges", n, 9);
    @(negedge clock);
    chk("up_170", pulse_width, 32'd170);
    repeat (4) @(negedge clock);
    do_reset();
    cycles_to_tick(n);
    chk("tick_after_midramp_reset", n, 9);
    @(negedge clock);
    chk("up_170b", pulse_width, 32'd170);
    next_pw(pw); chk("up_190", pw, 32'd190);
    chk("up_busy", 32'(busy), 32'd1);
    next_pw(pw); chk("up_200", pw, 32'd200);
    chk("up_done", 32'(at_target), 32'd1);

    // Ramp down to the lower clamp.
    @(negedge clock); do_reset();
    target = 32'd0; enable = 1'b1;
    next_pw(pw); chk("dn_130", pw, 32'd130);
    next_pw(pw); chk("dn_110", pw, 32'd110);
    next_pw(pw); chk("dn_100", pw, 32'd100);
    next_pw(pw); chk("dn_hold", pw, 32'd100);

    // Target lowered mid-ramp: no overshoot.
    do_reset();
    target = 32'd200; enable = 1'b1;
    next_pw(pw); chk("chg_170", pw, 32'd170);
    target = 32'd160;
    next_pw(pw); chk("chg_160", pw, 32'd160);
    chk("chg_idle", 32'(at_target), 32'd1);

    // Disabled: frames keep ticking, pw frozen; resumes on the next tick.
    do_reset();
    target = 32'd200; enable = 1'b0;
    cycles_to_tick(n); chk("dis_first", n, 9);
    cycles_to_tick(n); chk("dis_period1", n, 10);
    cycles_to_tick(n); chk("dis_period2", n, 10);
    @(negedge clock);
    chk("dis_hold", pulse_width, 32'd150);
    enable = 1'b1;
    next_pw(pw); chk("en_170", pw, 32'd170);

    // Max target: clamped, no wrap.
    do_reset();
    target = 32'hFFFF_FFFF; enable = 1'b1;
    next_pw(pw); chk("max_170", pw, 32'd170);
    next_pw(pw); chk("max_190", pw, 32'd190);
    next_pw(pw); chk("max_200", pw, 32'd200);
    next_pw(pw); chk("max_hold", pw, 32'd200);

    // Randomized targets, enables and occasional resets against the reference.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clock);
      if ($urandom_range(0, 6) == 0) begin
        case ($urandom_range(0, 4))
          0: target = 32'd0;
          1: target = 32'hFFFF_FFFF;
          2: target = 32'($urandom_range(100, 200));
          3: target = 32'($urandom_range(0, 400));
          default: target = $urandom;
        endcase
      end
      if ($urandom_range(0, 9) == 0) enable = ~enable;
      if ($urandom_range(0, 300) == 0) do_reset();
    end

    @(negedge clock);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
